// File: rtl/xmul_pipe_vr.sv
// xmul_pipe_vr: pipelined DATA_W x DATA_W multiplier with valid/ready flow
// control on both sides. Signed/unsigned mode is chosen per operation and a
// user tag rides along with every operation. A stalled output freezes the
// whole pipeline.
// The optional build macro XMUL_ACC_EN adds the in_acc port and a running
// accumulator that is applied as an operation enters the output register.
module xmul_pipe_vr #(
  parameter int DATA_W     = 16,
  parameter int PIPE_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic                  op_signed,
`ifdef XMUL_ACC_EN
  input  logic                  in_acc,
`endif
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   product,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int PW = 2 * DATA_W;
  // Control word carried down the pipe: the tag, plus the accumulate flag
  // in the top bit when the accumulator is built in.
`ifdef XMUL_ACC_EN
  localparam int CW = TAG_W + 1;
`else
  localparam int CW = TAG_W;
`endif

  // Extend both operands to PW bits and multiply; the low PW bits are the
  // exact product in either mode.
  function automatic logic [PW-1:0] ext_mul(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic              s);
    logic [PW-1:0] ae;
    logic [PW-1:0] be;
    ae = s ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    be = s ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    return ae * be;
  endfunction

  logic          out_valid_r;
  logic [PW-1:0] product_r;
  logic [TAG_W-1:0] out_tag_r;
  logic          adv_s;
  logic [CW-1:0] ctl_in_s;
  logic          src_v_s;
  logic [PW-1:0] src_p_s;
  logic [CW-1:0] src_c_s;
  logic [PW-1:0] res_s;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign adv_s    = !out_valid_r || out_ready;
  assign in_ready = adv_s;

`ifdef XMUL_ACC_EN
  assign ctl_in_s = {in_acc, in_tag};
`else
  assign ctl_in_s = in_tag;
`endif

  generate
    if (PIPE_DEPTH == 1) begin : g_direct
      // Single stage: the output register is loaded straight from the inputs.
      assign src_v_s = in_valid;
      assign src_p_s = ext_mul(op_a, op_b, op_signed);
      assign src_c_s = ctl_in_s;
    end else begin : g_staged
      logic              v1_r;
      logic              s1_r;
      logic [DATA_W-1:0] a1_r;
      logic [DATA_W-1:0] b1_r;
      logic [CW-1:0]     c1_r;
      logic [PW-1:0]     m1_s;

      assign m1_s = ext_mul(a1_r, b1_r, s1_r);

      // Stage 1: capture operands, mode and control word on every advance.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1_r <= 1'b0;
          s1_r <= 1'b0;
          a1_r <= '0;
          b1_r <= '0;
          c1_r <= '0;
        end else if (adv_s) begin
          v1_r <= in_valid;
          s1_r <= op_signed;
          a1_r <= op_a;
          b1_r <= op_b;
          c1_r <= ctl_in_s;
        end
      end

      if (PIPE_DEPTH == 2) begin : g_short
        // Product is formed between stage 1 and the output register.
        assign src_v_s = v1_r;
        assign src_p_s = m1_s;
        assign src_c_s = c1_r;
      end else begin : g_long
        localparam int NM = PIPE_DEPTH - 2;
        logic [NM-1:0] v_r;
        logic [PW-1:0] p_r [NM];
        logic [CW-1:0] c_r [NM];

        // Product stages: slot 0 takes the fresh product, later slots shift it on.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_r <= '0;
            for (int k = 0; k < NM; k++) begin
              p_r[k] <= '0;
              c_r[k] <= '0;
            end
          end else if (adv_s) begin
            v_r[0] <= v1_r;
            p_r[0] <= m1_s;
            c_r[0] <= c1_r;
            for (int k = 1; k < NM; k++) begin
              v_r[k] <= v_r[k-1];
              p_r[k] <= p_r[k-1];
              c_r[k] <= c_r[k-1];
            end
          end
        end

        assign src_v_s = v_r[NM-1];
        assign src_p_s = p_r[NM-1];
        assign src_c_s = c_r[NM-1];
      end
    end
  endgenerate

`ifdef XMUL_ACC_EN
  logic [PW-1:0] acc_r;

  // Result entering the output register: product plus the running sum when requested.
  always_comb begin
    res_s = src_p_s;
    if (src_c_s[TAG_W]) begin
      res_s = src_p_s + acc_r;
    end else begin
      res_s = src_p_s;
    end
  end

  // Accumulator follows each valid operation that moves into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (adv_s && src_v_s) begin
      acc_r <= res_s;
    end
  end
`else
  assign res_s = src_p_s;
`endif

  // Output register: loads the last stage on advance, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      product_r   <= '0;
      out_tag_r   <= '0;
    end else if (adv_s) begin
      out_valid_r <= src_v_s;
      product_r   <= res_s;
      out_tag_r   <= src_c_s[TAG_W-1:0];
    end
  end

  assign out_valid = out_valid_r;
  assign product   = product_r;
  assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_xmul_pipe_vr.sv
// Self-checking bench for xmul_pipe_vr. Three instances (depth 4, 1 and 8)
// share one input stream; each has its own in-order scoreboard built from
// plain integer multiplication. Only the depth-4 instance sees backpressure.
// Define XMUL_ACC_EN on both files to exercise the accumulator build.
module tb_xmul_pipe_vr;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int NDUT = 3;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  t;
    int          e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] op_a = 16'h0;
  logic [DW-1:0] op_b = 16'h0;
  logic op_signed = 1'b0;
  logic [TW-1:0] in_tag = 4'h0;
  logic in_acc = 1'b0;
  logic out_ready = 1'b1;
  logic rand_rdy = 1'b0;

  logic ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0] p0, p1, p2;
  logic [3:0] t0, t1, t2;

  int ntests = 0;
  int nfail = 0;
  int ecnt = 0;
  int acc0_cnt = 0;
  exp_t q [NDUT][$];
  logic [31:0] acc_m [NDUT];
  int last_stall [NDUT];
  logic [31:0] got0 [$];
  logic [15:0] ra [200];
  logic [15:0] rb [200];

  always #5 clk = ~clk;

  xmul_pipe_vr #(.DATA_W(16), .PIPE_DEPTH(4), .TAG_W(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .op_a(op_a), .op_b(op_b), .op_signed(op_signed),
`ifdef XMUL_ACC_EN
    .in_acc(in_acc),
`endif
    .in_tag(in_tag), .out_valid(ov0), .out_ready(out_ready),
    .product(p0), .out_tag(t0));

  xmul_pipe_vr #(.DATA_W(16), .PIPE_DEPTH(1), .TAG_W(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .op_a(op_a), .op_b(op_b), .op_signed(op_signed),
`ifdef XMUL_ACC_EN
    .in_acc(in_acc),
`endif
    .in_tag(in_tag), .out_valid(ov1), .out_ready(1'b1),
    .product(p1), .out_tag(t1));

  xmul_pipe_vr #(.DATA_W(16), .PIPE_DEPTH(8), .TAG_W(4)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .op_a(op_a), .op_b(op_b), .op_signed(op_signed),
`ifdef XMUL_ACC_EN
    .in_acc(in_acc),
`endif
    .in_tag(in_tag), .out_valid(ov2), .out_ready(1'b1),
    .product(p2), .out_tag(t2));

  // Edge counter used to measure latency.
  always @(posedge clk) ecnt <= ecnt + 1;

  // Consumer readiness: random while rand_rdy is set, otherwise always ready.
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic int dep(input int id);
    case (id)
      0: return 4;
      1: return 1;
      default: return 8;
    endcase
  endfunction

  // Reference product: plain integer multiply of the operands read as signed or unsigned.
  function automatic logic [31:0] mul_ref(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint x, y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return 32'(x * y);
  endfunction

  task automatic check(input int id, input logic ov, input logic [31:0] p, input logic [3:0] t,
                       input logic ordy, input logic irdy);
    exp_t e;
    logic [31:0] r;
    ntests++;
    if (irdy !== (!ov || ordy)) begin
      nfail++;
      $display("FAIL in_ready dut%0d got %b exp %b", id, irdy, (!ov || ordy));
    end
    if (ov && ordy) begin
      if (q[id].size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL spurious dut%0d got product %h tag %h exp no output", id, p, t);
      end else begin
        e = q[id].pop_front();
        ntests++;
        if (p !== e.p || t !== e.t) begin
          nfail++;
          $display("FAIL result dut%0d got %h/%h exp %h/%h", id, p, t, e.p, e.t);
        end
        if (last_stall[id] < e.e) begin
          ntests++;
          if (ecnt - e.e != dep(id) - 1) begin
            nfail++;
            $display("FAIL latency dut%0d got %0d exp %0d", id, ecnt - e.e + 1, dep(id));
          end
        end
        if (id == 0) got0.push_back(p);
      end
    end
    if (ov && !ordy) last_stall[id] = ecnt;
    if (in_valid && irdy) begin
      r = mul_ref(op_a, op_b, op_signed);
`ifdef XMUL_ACC_EN
      if (in_acc) r = r + acc_m[id];
      acc_m[id] = r;
`endif
      e.p = r;
      e.t = in_tag;
      e.e = ecnt + 1;
      q[id].push_back(e);
      if (id == 0) acc0_cnt++;
    end
  endtask

  // Single compare process: every instance is checked on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check(0, ov0, p0, t0, out_ready, ir0);
      check(1, ov1, p1, t1, 1'b1, ir1);
      check(2, ov2, p2, t2, 1'b1, ir2);
    end
  end

  task automatic clear_models();
    for (int i = 0; i < NDUT; i++) begin
      q[i].delete();
      acc_m[i] = 32'h0;
      last_stall[i] = -1;
    end
    got0.delete();
  endtask

  task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [3:0] t, input logic ac);
    int g;
    @(posedge clk);
    #1;
    in_valid = 1'b1; op_a = a; op_b = b; op_signed = s; in_tag = t; in_acc = ac;
    g = 0;
    @(negedge clk);
    while (!ir0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!ir0) begin
      ntests++;
      nfail++;
      $display("FAIL accept_timeout got in_ready 0 exp 1");
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_acc = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    ntests++;
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      nfail++;
      $display("FAIL drain_timeout got %0d pending exp 0", q[0].size() + q[1].size() + q[2].size());
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic expect_got(input string name, input int idx, input logic [31:0] v);
    ntests++;
    if (idx >= got0.size()) begin
      nfail++;
      $display("FAIL %s got missing exp %h", name, v);
    end else if (got0[idx] !== v) begin
      nfail++;
      $display("FAIL %s got %h exp %h", name, got0[idx], v);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lit;
    clear_models();
    // Reset state
    #3;
    ntests++;
    if (ov0 !== 1'b0 || p0 !== 32'h0 || t0 !== 4'h0) begin
      nfail++;
      $display("FAIL reset_state got %b/%h/%h exp 0/0/0", ov0, p0, t0);
    end
    #9 rst_n = 1'b1;
    #1;
    ntests++;
    if (ir0 !== 1'b1) begin
      nfail++;
      $display("FAIL reset_in_ready got %b exp 1", ir0);
    end

    // Model pinned by hand-computed values
    lit = mul_ref(16'h8000, 16'h8000, 1'b1);
    ntests++;
    if (lit !== 32'h40000000) begin nfail++; $display("FAIL model_minmin got %h exp 40000000", lit); end
    lit = mul_ref(16'hFFFF, 16'hFFFF, 1'b0);
    ntests++;
    if (lit !== 32'hFFFE0001) begin nfail++; $display("FAIL model_maxmax got %h exp fffe0001", lit); end
    lit = mul_ref(16'hFFFF, 16'h0002, 1'b1);
    ntests++;
    if (lit !== 32'hFFFFFFFE) begin nfail++; $display("FAIL model_neg got %h exp fffffffe", lit); end

    // T1 / T5: 200 random signed ops, then the same operands unsigned
    for (int i = 0; i < 200; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
    end
    for (int i = 0; i < 200; i++) push_op(ra[i], rb[i], 1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 200; i++) push_op(ra[i], rb[i], 1'b0, 4'(i), 1'b0);
    drain();

    // T2: directed corner products
    got0.delete();
    push_op(16'd0, 16'd1, 1'b0, 4'h1, 1'b0);
    push_op(16'd1, 16'd0, 1'b0, 4'h2, 1'b0);
    push_op(16'd10, 16'd1, 1'b0, 4'h3, 1'b0);
    push_op(16'd1, 16'd10, 1'b0, 4'h4, 1'b0);
    push_op(16'hFFFF, 16'hFFFF, 1'b1, 4'h5, 1'b0);
    push_op(16'hFFFF, 16'hFFFF, 1'b0, 4'h6, 1'b0);
    push_op(16'h8000, 16'h8000, 1'b1, 4'h7, 1'b0);
    drain();
    expect_got("t2_0x1", 0, 32'd0);
    expect_got("t2_1x0", 1, 32'd0);
    expect_got("t2_10x1", 2, 32'd10);
    expect_got("t2_1x10", 3, 32'd10);
    expect_got("t2_m1xm1", 4, 32'd1);
    expect_got("t2_ffff_sq", 5, 32'hFFFE0001);
    expect_got("t2_8000_sq", 6, 32'h40000000);

    // T3: 20 ops under random backpressure
    got0.delete();
    acc0_cnt = 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) push_op(16'($urandom), 16'($urandom), 1'($urandom), 4'(i), 1'b0);
    idle();
    rand_rdy = 1'b0;
    drain();
    ntests++;
    if (acc0_cnt != 20 || got0.size() != 20) begin
      nfail++;
      $display("FAIL t3_count got %0d/%0d exp 20/20", acc0_cnt, got0.size());
    end

    // T4: reset with operations in flight
    push_op(16'd3, 16'd5, 1'b0, 4'h1, 1'b0);
    push_op(16'd7, 16'd9, 1'b0, 4'h2, 1'b0);
    push_op(16'd11, 16'd13, 1'b0, 4'h3, 1'b0);
    idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    ntests++;
    if (ov0 !== 1'b0 || p0 !== 32'h0 || ov2 !== 1'b0) begin
      nfail++;
      $display("FAIL t4_reset got %b/%h/%b exp 0/0/0", ov0, p0, ov2);
    end
    clear_models();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_op(16'd123, 16'd45, 1'b0, 4'h9, 1'b0);
    drain();
    ntests++;
    if (got0.size() != 1) begin
      nfail++;
      $display("FAIL t4_count got %0d exp 1", got0.size());
    end
    expect_got("t4_after", 0, 32'd5535);

`ifdef XMUL_ACC_EN
    // T6: accumulate chain, without and then with stalls
    for (int pass = 0; pass < 2; pass++) begin
      got0.delete();
      rand_rdy = (pass == 1);
      push_op(16'd3, 16'd4, 1'b0, 4'h1, 1'b0);
      push_op(16'd5, 16'd6, 1'b0, 4'h2, 1'b1);
      push_op(16'd2, 16'd2, 1'b0, 4'h3, 1'b1);
      push_op(16'd7, 16'd1, 1'b0, 4'h4, 1'b0);
      idle();
      rand_rdy = 1'b0;
      drain();
      expect_got("t6_12", 0, 32'd12);
      expect_got("t6_42", 1, 32'd42);
      expect_got("t6_46", 2, 32'd46);
      expect_got("t6_7", 3, 32'd7);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
